// File: rtl/memory_response_unit_if.sv
// Request/response bundle between a core port and its memory responder.
// The core drives read/write/address/in_data/byte_en; the responder drives the rest.
interface memory_response_unit_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  logic                      read;
  logic                      write;
  logic [ADDRESS_BITS-1:0]   address;
  logic [DATA_WIDTH-1:0]     in_data;
  logic [DATA_WIDTH/8-1:0]   byte_en;
  logic                      ready;
  logic                      valid;
  logic [ADDRESS_BITS-1:0]   address_out;
  logic [DATA_WIDTH-1:0]     out_data;

  // Handshake: a request is taken on any rising edge where (read|write) and ready
  // are both high; the requester holds it otherwise. valid is a one-cycle pulse
  // with no back-pressure, and address_out/out_data hold until the next read.
  modport master (
    output read, write, address, in_data, byte_en,
    input  ready, valid, address_out, out_data
  );

  modport slave (
    input  read, write, address, in_data, byte_en,
    output ready, valid, address_out, out_data
  );
endinterface

// File: rtl/memory_response_unit.sv
// Fixed-latency memory responder: one outstanding read or write into a local word
// array, read data returned with its address after LATENCY cycles.
module memory_response_unit #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int INDEX_BITS   = 10,
  parameter int LATENCY      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  memory_response_unit_if.slave bus,
  output logic [1:0]            o_dbg_state
);

  localparam int         NB       = DATA_WIDTH / 8;
  localparam int         DEPTH    = 1 << INDEX_BITS;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  if (CORE < 0 || LATENCY < 1 || LATENCY > 15 || (DATA_WIDTH % 8) != 0) begin : g_bad_cfg
    $error("memory_response_unit: illegal configuration (LATENCY must be 1..15)");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state, w_next_state;
  logic [3:0]              r_count, w_next_count;
  logic                    r_is_read, r_is_write;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [NB-1:0]           r_be;
  logic                    r_valid;
  logic [ADDRESS_BITS-1:0] r_addr_out;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_complete;
  logic [INDEX_BITS-1:0]   w_idx;

  assign w_ready  = (r_state != S_BUSY);
  assign w_accept = (bus.read | bus.write) & w_ready;
  assign w_idx    = r_addr[INDEX_BITS+1:2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
    end
  end

  // An accept in DONE overrides the return to IDLE, so requests can issue every LATENCY cycles.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: w_next_state = S_IDLE;
      S_BUSY: begin
        if (r_count <= 4'd1) begin
          w_next_state = S_DONE;
          w_next_count = 4'd0;
        end else begin
          w_next_count = r_count - 4'd1;
        end
      end
      S_DONE: begin
        w_complete   = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_accept) begin
      w_next_state = (LATENCY > 1) ? S_BUSY : S_DONE;
      w_next_count = CNT_LOAD;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_is_read  <= 1'b0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_be       <= '0;
      r_valid    <= 1'b0;
      r_addr_out <= '0;
      r_out_data <= '0;
    end else begin
      r_valid <= w_complete & r_is_read;
      if (w_complete && r_is_read) begin
        r_out_data <= r_mem[w_idx];
        r_addr_out <= r_addr;
      end
      // A simultaneous read and write is a write; the read half is dropped.
      if (w_accept) begin
        r_is_read  <= bus.read & ~bus.write;
        r_is_write <= bus.write;
        r_addr     <= bus.address;
        r_data     <= bus.in_data;
        r_be       <= bus.byte_en;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_complete && r_is_write) begin
      for (int i = 0; i < NB; i++) begin
        if (r_be[i]) r_mem[w_idx][i*8 +: 8] <= r_data[i*8 +: 8];
      end
    end
  end

  assign bus.ready       = w_ready;
  assign bus.valid       = r_valid;
  assign bus.address_out = r_addr_out;
  assign bus.out_data    = r_out_data;
  assign o_dbg_state     = r_state;

endmodule
